alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3, meaning the number of EXEC cycles held for a multiply (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1, opcode input 4, op_a input 32, op_b input 32: request channel.
REQ-005 SHALL have ports out_valid output 1, out_ready input 1, result output 32, carry_out output 1, illegal_op output 1: response channel.
REQ-006 SHALL have datapath-drive ports dp_a output 32, dp_b output 32, arithmic_op, sub, logic_op, shift_op, shift_right, mul_op, trans_op, trans_sel (all output 1), sel output 2.
REQ-007 SHALL have datapath-return ports dp_y input 32 and dp_carry input 1.

Function
REQ-008 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-009 In IDLE, in_ready SHALL be 1; in EXEC and DONE it SHALL be 0. Only one operation is in flight.
REQ-010 On in_valid && in_ready, SHALL register opcode, op_a and op_b and move to EXEC the next cycle.
REQ-011 dp_a and dp_b SHALL always drive the registered operands.
REQ-012 In EXEC, SHALL decode the registered opcode into exactly one asserted op-class control. Decode: 0 ADD (arithmic_op); 1 SUB (arithmic_op, sub); 2-5 logic (logic_op, sel = opcode-2); 6 SHL (shift_op); 7 SHR (shift_op, shift_right); 8 MUL (mul_op); 9 TRANS0 (trans_op, trans_sel=0); 10 TRANS1 (trans_op, trans_sel=1).
REQ-013 All datapath controls SHALL be 0 in IDLE and DONE, and for opcodes 11-15.
REQ-014 For non-MUL opcodes, EXEC SHALL last exactly 1 cycle.
REQ-015 For MUL, EXEC SHALL last exactly MUL_CYCLES cycles, timed by a 4-bit down-counter loaded on accept.
REQ-016 On the last EXEC cycle, SHALL register result from dp_y, and register carry_out from dp_carry for opcodes 0/1 (0 otherwise), then enter DONE.
REQ-017 Opcodes 11-15 SHALL complete as a 1-cycle EXEC with result 0, carry_out 0 and illegal_op 1; illegal_op SHALL be 0 for legal opcodes.
REQ-018 In DONE, out_valid SHALL be 1, and result, carry_out and illegal_op SHALL stay stable until out_ready.
REQ-019 On out_valid && out_ready, SHALL go to IDLE the next cycle.
REQ-020 There SHALL be no DONE-to-EXEC bypass.
REQ-021 Latency for non-MUL SHALL be: accept in cycle N, out_valid first high in cycle N+2. For MUL, out_valid is first high in cycle N+1+MUL_CYCLES.
REQ-022 Changes to in_valid, opcode and the operand inputs while not in IDLE SHALL be ignored.

Reset
REQ-023 With rst high at a rising edge, SHALL enter IDLE.
REQ-024 Reset values: out_valid=0, result=0, carry_out=0, illegal_op=0, registered operands=0, counter=0, all datapath controls=0. in_ready=1 from the first cycle after reset.
REQ-025 Reset in EXEC or DONE SHALL abort and discard the operation without emitting a response.

Configuration
REQ-026 With macro ALU_SEQUENCER_OP_COUNT_EN defined, SHALL add output op_count (32 bits, reset 0), incremented on each out_valid && out_ready handshake. It wraps 0xFFFFFFFF->0 and also counts illegal ops.
REQ-027 Without ALU_SEQUENCER_OP_COUNT_EN, port op_count and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-028 ADD: opcode 0, A=0xFFFFFFFF, B=1, out_ready=1 -> out_valid at N+2, result 0x00000000, carry_out 1, arithmic_op high only during the EXEC cycle.
REQ-029 SUB: opcode 1, A=5, B=7, model datapath -> result 0xFFFFFFFE, sub=1 and arithmic_op=1 in EXEC, in_ready 0 until handshake.
REQ-030 MUL with MUL_CYCLES=3: opcode 8, A=6, B=7 -> mul_op high exactly 3 cycles, out_valid at N+4, result 42, carry_out 0.
REQ-031 Backpressure: out_ready held 0 for 5 cycles in DONE -> result stable, in_ready 0, a new in_valid is not accepted; release -> IDLE next cycle.
REQ-032 Illegal and reset: opcode 13 -> result 0, illegal_op 1, no control asserted. Then rst during a MUL EXEC -> no out_valid; in_ready 1 the cycle after rst deasserts.
REQ-033 With ALU_SEQUENCER_OP_COUNT_EN: after 3 completed ops op_count=3; with the counter forced to 0xFFFFFFFF, one more handshake -> op_count 0.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Request, response and datapath-drive signals of alu_sequencer.
// slave = the sequencer; master = upstream requester plus the external datapath.
interface alu_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [31:0] op_a;
  logic [31:0] op_b;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        illegal_op;

  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic        arithmic_op;
  logic        sub;
  logic        logic_op;
  logic        shift_op;
  logic        shift_right;
  logic        mul_op;
  logic        trans_op;
  logic        trans_sel;
  logic [1:0]  sel;
  logic [31:0] dp_y;
  logic        dp_carry;

  modport slave (
    input  in_valid, opcode, op_a, op_b, out_ready, dp_y, dp_carry,
    output in_ready, out_valid, result, carry_out, illegal_op,
    output dp_a, dp_b, arithmic_op, sub, logic_op, shift_op, shift_right,
    output mul_op, trans_op, trans_sel, sel
  );

  modport master (
    output in_valid, opcode, op_a, op_b, out_ready, dp_y, dp_carry,
    input  in_ready, out_valid, result, carry_out, illegal_op,
    input  dp_a, dp_b, arithmic_op, sub, logic_op, shift_op, shift_right,
    input  mul_op, trans_op, trans_sel, sel
  );
endinterface

// File: rtl/alu_sequencer.sv
// One-in-flight ALU sequencer: accepts an op, drives an external datapath, holds the response.
// Optional handshake counter output op_count is enabled by defining ALU_SEQUENCER_OP_COUNT_EN.
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst,
  alu_sequencer_if.slave     bus
`ifdef ALU_SEQUENCER_OP_COUNT_EN
  ,
  output logic [31:0]        op_count
`endif
);

  // state | meaning
  // IDLE  | ready for a request, datapath controls low
  // EXEC  | one op-class control asserted, counter runs down
  // DONE  | response held on out_valid until out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);

  logic [1:0]  r_state;
  logic [3:0]  r_opcode;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_cnt;
  logic [31:0] r_result;
  logic        r_carry;
  logic        r_illegal;

  logic        w_exec;
  logic        w_last;
  logic        w_illegal;
  logic        w_arith;
  logic        w_sub;
  logic        w_logic;
  logic        w_shift;
  logic        w_shr;
  logic        w_mul;
  logic        w_trans;
  logic        w_tsel;
  logic [1:0]  w_sel;

  assign w_exec    = (r_state == S_EXEC);
  assign w_last    = (r_cnt == 4'd1);
  assign w_illegal = (r_opcode > 4'd10);

  always_comb begin
    w_arith = 1'b0;
    w_sub   = 1'b0;
    w_logic = 1'b0;
    w_shift = 1'b0;
    w_shr   = 1'b0;
    w_mul   = 1'b0;
    w_trans = 1'b0;
    w_tsel  = 1'b0;
    w_sel   = 2'd0;
    if (w_exec) begin
      case (r_opcode)
        4'd0: w_arith = 1'b1;
        4'd1: begin
          w_arith = 1'b1;
          w_sub   = 1'b1;
        end
        4'd2, 4'd3, 4'd4, 4'd5: begin
          w_logic = 1'b1;
          // opcode-2 for 2..5, taken on the low two bits
          w_sel   = r_opcode[1:0] - 2'd2;
        end
        4'd6: w_shift = 1'b1;
        4'd7: begin
          w_shift = 1'b1;
          w_shr   = 1'b1;
        end
        4'd8: w_mul = 1'b1;
        4'd9: w_trans = 1'b1;
        4'd10: begin
          w_trans = 1'b1;
          w_tsel  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_opcode  <= 4'd0;
      r_a       <= 32'd0;
      r_b       <= 32'd0;
      r_cnt     <= 4'd0;
      r_result  <= 32'd0;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_opcode <= bus.opcode;
            r_a      <= bus.op_a;
            r_b      <= bus.op_b;
            r_cnt    <= (bus.opcode == OP_MUL) ? MUL_LOAD : 4'd1;
            r_state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_last) begin
            r_result  <= w_illegal ? 32'd0 : bus.dp_y;
            r_carry   <= w_arith & bus.dp_carry;
            r_illegal <= w_illegal;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQUENCER_OP_COUNT_EN
  logic [31:0] r_op_count;

  always_ff @(posedge clk) begin
    if (rst) r_op_count <= 32'd0;
    else if ((r_state == S_DONE) && bus.out_ready) r_op_count <= r_op_count + 32'd1;
  end

  assign op_count = r_op_count;
`endif

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.result      = r_result;
  assign bus.carry_out   = r_carry;
  assign bus.illegal_op  = r_illegal;
  assign bus.dp_a        = r_a;
  assign bus.dp_b        = r_b;
  assign bus.arithmic_op = w_arith;
  assign bus.sub         = w_sub;
  assign bus.logic_op    = w_logic;
  assign bus.shift_op    = w_shift;
  assign bus.shift_right = w_shr;
  assign bus.mul_op      = w_mul;
  assign bus.trans_op    = w_trans;
  assign bus.trans_sel   = w_tsel;
  assign bus.sel         = w_sel;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with a behavioural datapath model.
module tb_alu_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   hs_count;

  alu_sequencer_if bus ();

`ifdef ALU_SEQUENCER_OP_COUNT_EN
  logic [31:0] op_count;
  alu_sequencer #(.MUL_CYCLES(3)) dut (.clk(clk), .rst(rst), .bus(bus), .op_count(op_count));
`else
  alu_sequencer #(.MUL_CYCLES(3)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] w_ctrl;
  assign w_ctrl = {bus.arithmic_op, bus.sub, bus.logic_op, bus.shift_op, bus.shift_right,
                   bus.mul_op, bus.trans_op, bus.trans_sel, bus.sel};

  // Datapath model; idle outputs are deliberately non-zero so zeroing in the DUT is visible.
  logic [32:0] dp_t;
  always_comb begin
    dp_t         = 33'd0;
    bus.dp_y     = bus.dp_a ^ bus.dp_b ^ 32'h5A5A_5A5A;
    bus.dp_carry = 1'b1;
    if (bus.arithmic_op) begin
      dp_t = bus.sub ? ({1'b0, bus.dp_a} + {1'b0, ~bus.dp_b} + 33'd1)
                     : ({1'b0, bus.dp_a} + {1'b0, bus.dp_b});
      bus.dp_y     = dp_t[31:0];
      bus.dp_carry = dp_t[32];
    end else if (bus.logic_op) begin
      case (bus.sel)
        2'd0: bus.dp_y = bus.dp_a & bus.dp_b;
        2'd1: bus.dp_y = bus.dp_a | bus.dp_b;
        2'd2: bus.dp_y = bus.dp_a ^ bus.dp_b;
        default: bus.dp_y = ~(bus.dp_a | bus.dp_b);
      endcase
    end else if (bus.shift_op) begin
      bus.dp_y = bus.shift_right ? (bus.dp_a >> bus.dp_b[4:0]) : (bus.dp_a << bus.dp_b[4:0]);
    end else if (bus.mul_op) begin
      bus.dp_y = bus.dp_a * bus.dp_b;
    end else if (bus.trans_op) begin
      bus.dp_y = bus.trans_sel ? bus.dp_b : bus.dp_a;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        ill;
    logic [9:0]  ctrl;
    int          lat;
    int          cyc;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    int lat;
    int cyc;
    @(negedge clk);
    chk($sformatf("v%0d in_ready idle", i), 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.opcode    = vecs[i].op;
    bus.op_a      = vecs[i].a;
    bus.op_b      = vecs[i].b;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.opcode   = 4'hF;
    bus.op_a     = 32'hDEAD_BEEF;
    bus.op_b     = 32'h0BAD_F00D;
    chk($sformatf("v%0d in_ready exec", i), 32'(bus.in_ready), 32'd0);
    chk($sformatf("v%0d ctrl", i), 32'(w_ctrl), 32'(vecs[i].ctrl));
    chk($sformatf("v%0d dp_a", i), bus.dp_a, vecs[i].a);
    lat = 1;
    cyc = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      if (w_ctrl != 10'd0) cyc++;
      @(negedge clk);
      lat++;
    end
    if (w_ctrl != 10'd0) cyc++;
    chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
    chk($sformatf("v%0d ctrl cycles", i), 32'(cyc), 32'(vecs[i].cyc));
    chk($sformatf("v%0d result", i), bus.result, vecs[i].res);
    chk($sformatf("v%0d carry", i), 32'(bus.carry_out), 32'(vecs[i].c));
    chk($sformatf("v%0d illegal", i), 32'(bus.illegal_op), 32'(vecs[i].ill));
    @(negedge clk);
    hs_count++;
    chk($sformatf("v%0d out_valid after hs", i), 32'(bus.out_valid), 32'd0);
    chk($sformatf("v%0d in_ready after hs", i), 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int  n;
    logic ov_seen;
    checks    = 0;
    failures  = 0;
    hs_count  = 0;
    rst       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.opcode    = 4'd0;
    bus.op_a      = 32'd0;
    bus.op_b      = 32'd0;
    bus.out_ready = 1'b0;

    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'd1,          32'h0000_0000, 1'b1, 1'b0, 10'b1000000000, 2, 1};
    vecs[1]  = '{4'd1,  32'd5,         32'd7,          32'hFFFF_FFFE, 1'b0, 1'b0, 10'b1100000000, 2, 1};
    vecs[2]  = '{4'd0,  32'd3,         32'd4,          32'd7,         1'b0, 1'b0, 10'b1000000000, 2, 1};
    vecs[3]  = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 10'b0010000000, 2, 1};
    vecs[4]  = '{4'd3,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 10'b0010000001, 2, 1};
    vecs[5]  = '{4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 10'b0010000010, 2, 1};
    vecs[6]  = '{4'd5,  32'd0,         32'd0,          32'hFFFF_FFFF, 1'b0, 1'b0, 10'b0010000011, 2, 1};
    vecs[7]  = '{4'd6,  32'd1,         32'd4,          32'd16,        1'b0, 1'b0, 10'b0001000000, 2, 1};
    vecs[8]  = '{4'd7,  32'h8000_0000, 32'd31,         32'd1,         1'b0, 1'b0, 10'b0001100000, 2, 1};
    vecs[9]  = '{4'd8,  32'd6,         32'd7,          32'd42,        1'b0, 1'b0, 10'b0000010000, 4, 3};
    vecs[10] = '{4'd9,  32'hAAAA_5555, 32'h1111_2222, 32'hAAAA_5555, 1'b0, 1'b0, 10'b0000001000, 2, 1};
    vecs[11] = '{4'd10, 32'hAAAA_5555, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 10'b0000001100, 2, 1};
    vecs[12] = '{4'd13, 32'd9,         32'd3,          32'd0,         1'b0, 1'b1, 10'b0000000000, 2, 0};
    vecs[13] = '{4'd15, 32'hFFFF_FFFF, 32'd1,          32'd0,         1'b0, 1'b1, 10'b0000000000, 2, 0};
    vecs[14] = '{4'd11, 32'd1,         32'd2,          32'd0,         1'b0, 1'b1, 10'b0000000000, 2, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset carry", 32'(bus.carry_out), 32'd0);
    chk("reset illegal", 32'(bus.illegal_op), 32'd0);
    chk("reset dp_a", bus.dp_a, 32'd0);
    chk("reset ctrl", 32'(w_ctrl), 32'd0);
`ifdef ALU_SEQUENCER_OP_COUNT_EN
    chk("reset op_count", op_count, 32'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      run_vec(i);
`ifdef ALU_SEQUENCER_OP_COUNT_EN
      if (i == 2) chk("op_count after 3", op_count, 32'd3);
`endif
    end

    // Backpressure: response must hold and no new request may slip in.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.opcode    = 4'd0;
    bus.op_a      = 32'd3;
    bus.op_b      = 32'd4;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp reach done", 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.opcode   = 4'd1;
      bus.op_a     = 32'd99;
      @(negedge clk);
      chk($sformatf("bp hold%0d result", k), bus.result, 32'd7);
      chk($sformatf("bp hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp hold%0d dp_a", k), bus.dp_a, 32'd3);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    hs_count++;
    chk("bp release out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp release in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("bp no stray op", 32'(bus.in_ready), 32'd1);

    // Reset in the middle of a multiply discards it.
    bus.in_valid = 1'b1;
    bus.opcode   = 4'd8;
    bus.op_a     = 32'd6;
    bus.op_b     = 32'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("rst pre mul_op", 32'(bus.mul_op), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hs_count = 0;
    chk("rst abort in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst abort result", bus.result, 32'd0);
    chk("rst abort dp_a", bus.dp_a, 32'd0);
    chk("rst abort ctrl", 32'(w_ctrl), 32'd0);
    ov_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) ov_seen = 1'b1;
    end
    chk("rst abort no out_valid", 32'(ov_seen), 32'd0);
    chk("rst abort in_ready later", 32'(bus.in_ready), 32'd1);

`ifdef ALU_SEQUENCER_OP_COUNT_EN
    chk("op_count after rst", op_count, 32'd0);
    force dut.r_op_count = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_op_count;
    run_vec(2);
    chk("op_count wrap", op_count, 32'd0);
`else
    run_vec(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
